// File: rtl/alt_pfl_pgm_verify_multi_pkg.sv
// rtl/alt_pfl_pgm_verify_multi_pkg.sv - IR codes, status patterns and helpers for the PFL verify engine
package alt_pfl_verify_pkg;

   localparam logic [7:0] IR_INFO             = 8'h11;
   localparam logic [7:0] IR_READ_DATA        = 8'h12;
   localparam logic [7:0] IR_FIFOSM_EXIT      = 8'h0F;
   localparam logic [7:0] IR_LOAD_RESET_SHIFT = 8'h1C;
   localparam logic [7:0] IR_INC_COUNTER      = 8'h1D;
   localparam logic [7:0] IR_LOAD_MASK        = 8'h1E;
   localparam logic [7:0] IR_READ_ERRLOG      = 8'h1B;

   localparam logic [7:0] PAT_INFO   = 8'hA5;
   localparam logic [7:0] PAT_FIFOSM = 8'hC3;

   // Widest status vector (64 slots); callers keep the low NUM_SLOTS bits.
   function automatic logic [63:0] replicate_byte(input logic [7:0] b);
      return {8{b}};
   endfunction

endpackage

// File: rtl/alt_pfl_pgm_verify_multi_if.sv
// rtl/alt_pfl_pgm_verify_multi_if.sv - virtual JTAG hub signals between hub decode and the verify engine
interface alt_pfl_pgm_verify_multi_if #(
   parameter int PFL_IR_BITS = 5
);
   logic                   vjtag_tdi;
   logic                   vjtag_virtual_state_sdr;
   logic                   vjtag_virtual_state_uir;
   logic                   vjtag_virtual_state_udr;
   logic                   vjtag_virtual_state_cdr;
   logic [PFL_IR_BITS-1:0] vjtag_ir_in;
   logic                   vjtag_tdo;

   modport master (
      output vjtag_tdi, vjtag_virtual_state_sdr, vjtag_virtual_state_uir,
             vjtag_virtual_state_udr, vjtag_virtual_state_cdr, vjtag_ir_in,
      input  vjtag_tdo
   );

   modport slave (
      input  vjtag_tdi, vjtag_virtual_state_sdr, vjtag_virtual_state_uir,
             vjtag_virtual_state_udr, vjtag_virtual_state_cdr, vjtag_ir_in,
      output vjtag_tdo
   );
endinterface

// File: rtl/alt_pfl_jtag_shifter.sv
// rtl/alt_pfl_jtag_shifter.sv - parallel-load, shift-right scan register; shiftin enters at the MSB
module alt_pfl_jtag_shifter #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             shiftin,
   output logic             shiftout,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset)
         q <= RESET_VAL;
      else if (load)
         q <= data;
      else if (enable)
         q <= {shiftin, q[WIDTH-1:1]};
   end

   assign shiftout = q[0];

endmodule

// File: rtl/alt_pfl_pgm_verify_multi.sv
// rtl/alt_pfl_pgm_verify_multi.sv - vJTAG-driven flash read-back verify with status, mask and error log chains
module alt_pfl_pgm_verify_multi
   import alt_pfl_verify_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter int PFL_IR_BITS   = 5,
   parameter int NUM_SLOTS     = 16,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                  vjtag_tck,
   input  logic                  vjtag_reset,
   alt_pfl_pgm_verify_multi_if.slave vj,
   input  logic [DATA_WIDTH-1:0] flash_data_in,
   input  logic [DATA_WIDTH-1:0] ip_flash_data_in,
   output logic                  crc_verify_enable,
   output logic                  verify_fail
);

   localparam int SLOT_BITS = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1;
   localparam int ELOG_W    = 1 + SLOT_BITS + ERR_CNT_WIDTH;

   localparam logic [PFL_IR_BITS-1:0] C_INFO   = IR_INFO[PFL_IR_BITS-1:0];
   localparam logic [PFL_IR_BITS-1:0] C_RDATA  = IR_READ_DATA[PFL_IR_BITS-1:0];
   localparam logic [PFL_IR_BITS-1:0] C_FIFOSM = IR_FIFOSM_EXIT[PFL_IR_BITS-1:0];
   localparam logic [PFL_IR_BITS-1:0] C_LRS    = IR_LOAD_RESET_SHIFT[PFL_IR_BITS-1:0];
   localparam logic [PFL_IR_BITS-1:0] C_INC    = IR_INC_COUNTER[PFL_IR_BITS-1:0];
   localparam logic [PFL_IR_BITS-1:0] C_MASK   = IR_LOAD_MASK[PFL_IR_BITS-1:0];
   localparam logic [PFL_IR_BITS-1:0] C_ELOG   = IR_READ_ERRLOG[PFL_IR_BITS-1:0];

   localparam logic [63:0] INFO_WORD   = replicate_byte(PAT_INFO);
   localparam logic [63:0] FIFOSM_WORD = replicate_byte(PAT_FIFOSM);
   localparam logic [SLOT_BITS-1:0] LAST_SLOT = SLOT_BITS'(NUM_SLOTS - 1);

   logic [DATA_WIDTH-1:0]    flash_reg;
   logic [DATA_WIDTH-1:0]    mask;
   logic [DATA_WIDTH-1:0]    mask_shift_q;
   logic [SLOT_BITS-1:0]     slot;
   logic [NUM_SLOTS-1:0]     verify_status;
   logic [ERR_CNT_WIDTH-1:0] err_count;
   logic                     first_fail_valid;
   logic [SLOT_BITS-1:0]     first_fail_slot;
   logic                     match;
   logic                     status_tdo, elog_tdo, mask_tdo;
   logic [NUM_SLOTS-1:0]     status_chain_unused;
   logic [ELOG_W-1:0]        elog_chain_unused;

   wire ir_info   = (vj.vjtag_ir_in == C_INFO);
   wire ir_rdata  = (vj.vjtag_ir_in == C_RDATA);
   wire ir_fifosm = (vj.vjtag_ir_in == C_FIFOSM);
   wire ir_lrs    = (vj.vjtag_ir_in == C_LRS);
   wire ir_inc    = (vj.vjtag_ir_in == C_INC);
   wire ir_mask   = (vj.vjtag_ir_in == C_MASK);
   wire ir_elog   = (vj.vjtag_ir_in == C_ELOG);

   wire uir = vj.vjtag_virtual_state_uir;
   wire udr = vj.vjtag_virtual_state_udr;
   wire sdr = vj.vjtag_virtual_state_sdr;

   wire clear_evt = uir && ir_lrs;
   wire cmp_evt   = udr && ir_rdata;

   assign crc_verify_enable = ir_lrs;
   assign match = ((flash_reg ^ ip_flash_data_in) & mask) == '0;

   always_ff @(posedge vjtag_tck) begin
      if (vjtag_reset)
         flash_reg <= '0;
      else if (vj.vjtag_virtual_state_cdr && ir_rdata)
         flash_reg <= flash_data_in;
   end

   // Explicit wrap so non-power-of-two slot counts never reach an unused index.
   always_ff @(posedge vjtag_tck) begin
      if (vjtag_reset || clear_evt)
         slot <= '0;
      else if (uir && ir_inc)
         slot <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
   end

   always_ff @(posedge vjtag_tck) begin
      if (vjtag_reset || clear_evt)
         verify_status <= '1;
      else if (uir && ir_info)
         verify_status <= INFO_WORD[NUM_SLOTS-1:0];
      else if (uir && ir_fifosm)
         verify_status <= FIFOSM_WORD[NUM_SLOTS-1:0];
      else if (cmp_evt)
         verify_status[slot] <= verify_status[slot] & match;
   end

   always_ff @(posedge vjtag_tck) begin
      if (vjtag_reset || clear_evt) begin
         err_count        <= '0;
         first_fail_valid <= 1'b0;
         first_fail_slot  <= '0;
      end else if (cmp_evt && !match) begin
         if (err_count != '1)
            err_count <= err_count + 1'b1;
         if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_slot  <= slot;
         end
      end
   end

   always_ff @(posedge vjtag_tck) begin
      if (vjtag_reset) begin
         mask        <= '1;
         verify_fail <= 1'b0;
      end else begin
         if (udr && ir_mask)
            mask <= mask_shift_q;
         verify_fail <= ~&verify_status;
      end
   end

   // Loads on the clearing edge, so the chain holds the status from before the clear.
   alt_pfl_jtag_shifter #(.WIDTH(NUM_SLOTS)) u_status_chain (
      .clk      (vjtag_tck),
      .reset    (vjtag_reset),
      .enable   (sdr && ir_lrs),
      .load     (clear_evt),
      .data     (verify_status),
      .shiftin  (vj.vjtag_tdi),
      .shiftout (status_tdo),
      .q        (status_chain_unused)
   );

   alt_pfl_jtag_shifter #(.WIDTH(ELOG_W)) u_errlog_chain (
      .clk      (vjtag_tck),
      .reset    (vjtag_reset),
      .enable   (sdr && ir_elog),
      .load     (uir && ir_elog),
      .data     ({first_fail_valid, first_fail_slot, err_count}),
      .shiftin  (vj.vjtag_tdi),
      .shiftout (elog_tdo),
      .q        (elog_chain_unused)
   );

   alt_pfl_jtag_shifter #(.WIDTH(DATA_WIDTH), .RESET_VAL({DATA_WIDTH{1'b1}})) u_mask_shift (
      .clk      (vjtag_tck),
      .reset    (vjtag_reset),
      .enable   (sdr && ir_mask),
      .load     (1'b0),
      .data     ({DATA_WIDTH{1'b0}}),
      .shiftin  (vj.vjtag_tdi),
      .shiftout (mask_tdo),
      .q        (mask_shift_q)
   );

   always_comb begin
      vj.vjtag_tdo = 1'b0;
      if (ir_lrs)
         vj.vjtag_tdo = status_tdo;
      else if (ir_elog)
         vj.vjtag_tdo = elog_tdo;
      else if (ir_mask)
         vj.vjtag_tdo = mask_tdo;
   end

endmodule

// File: tb/tb_alt_pfl_pgm_verify_multi.sv
// tb/tb_alt_pfl_pgm_verify_multi.sv - directed bench for the verify engine at 16 and 12 status slots
module tb_alt_pfl_pgm_verify_multi;
   import alt_pfl_verify_pkg::*;

   logic        tck = 1'b0;
   logic        rst;
   logic        tdi, sdr, uir, udr, cdr;
   logic [4:0]  ir;
   logic [15:0] fdata, rdata;
   logic        crc16, crc12, vf16, vf12;
   logic [63:0] o16, o12;
   int          n_checks = 0;
   int          n_pass   = 0;
   logic        crc_ok;

   always #5 tck = ~tck;

   alt_pfl_pgm_verify_multi_if #(.PFL_IR_BITS(5)) vj16 ();
   alt_pfl_pgm_verify_multi_if #(.PFL_IR_BITS(5)) vj12 ();

   assign vj16.vjtag_tdi = tdi;
   assign vj16.vjtag_virtual_state_sdr = sdr;
   assign vj16.vjtag_virtual_state_uir = uir;
   assign vj16.vjtag_virtual_state_udr = udr;
   assign vj16.vjtag_virtual_state_cdr = cdr;
   assign vj16.vjtag_ir_in = ir;
   assign vj12.vjtag_tdi = tdi;
   assign vj12.vjtag_virtual_state_sdr = sdr;
   assign vj12.vjtag_virtual_state_uir = uir;
   assign vj12.vjtag_virtual_state_udr = udr;
   assign vj12.vjtag_virtual_state_cdr = cdr;
   assign vj12.vjtag_ir_in = ir;

   alt_pfl_pgm_verify_multi #(.DATA_WIDTH(16), .PFL_IR_BITS(5), .NUM_SLOTS(16), .ERR_CNT_WIDTH(8)) dut16 (
      .vjtag_tck         (tck),
      .vjtag_reset       (rst),
      .vj                (vj16.slave),
      .flash_data_in     (fdata),
      .ip_flash_data_in  (rdata),
      .crc_verify_enable (crc16),
      .verify_fail       (vf16)
   );

   alt_pfl_pgm_verify_multi #(.DATA_WIDTH(16), .PFL_IR_BITS(5), .NUM_SLOTS(12), .ERR_CNT_WIDTH(8)) dut12 (
      .vjtag_tck         (tck),
      .vjtag_reset       (rst),
      .vj                (vj12.slave),
      .flash_data_in     (fdata),
      .ip_flash_data_in  (rdata),
      .crc_verify_enable (crc12),
      .verify_fail       (vf12)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
   endtask

   task automatic set_ir(input logic [7:0] code);
      @(negedge tck);
      ir = code[4:0];
   endtask

   task automatic pulse_uir(input logic [7:0] code);
      @(negedge tck);
      ir  = code[4:0];
      uir = 1'b1;
      @(negedge tck);
      uir = 1'b0;
   endtask

   task automatic pulse_udr();
      @(negedge tck);
      udr = 1'b1;
      @(negedge tck);
      udr = 1'b0;
   endtask

   task automatic compare(input logic [15:0] f, input logic [15:0] r);
      @(negedge tck);
      ir    = IR_READ_DATA[4:0];
      fdata = f;
      rdata = r;
      cdr   = 1'b1;
      @(negedge tck);
      cdr = 1'b0;
      udr = 1'b1;
      @(negedge tck);
      udr = 1'b0;
   endtask

   task automatic scan(input int n, input logic [63:0] tin, output logic [63:0] r16, output logic [63:0] r12);
      r16 = '0;
      r12 = '0;
      for (int i = 0; i < n; i++) begin
         #1;
         r16[i] = vj16.vjtag_tdo;
         r12[i] = vj12.vjtag_tdo;
         crc_ok = crc_ok & crc16 & crc12;
         tdi = tin[i];
         sdr = 1'b1;
         @(negedge tck);
      end
      sdr = 1'b0;
      tdi = 1'b0;
   endtask

   initial begin
      rst = 1'b1; tdi = 0; sdr = 0; uir = 0; udr = 0; cdr = 0;
      ir = '0; fdata = '0; rdata = '0; crc_ok = 1'b1;
      repeat (2) @(negedge tck);
      rst = 1'b0;
      #1;
      check("reset_verify_fail", {63'd0, vf16}, 64'd0);
      check("reset_tdo", {63'd0, vj16.vjtag_tdo}, 64'd0);
      check("reset_crc_en", {63'd0, crc16}, 64'd0);

      // INFO pattern read out through the status chain
      pulse_uir(IR_INFO);
      pulse_uir(IR_LOAD_RESET_SHIFT);
      scan(16, 64'd0, o16, o12);
      check("info_scan16", o16, 64'hA5A5);
      check("info_scan12", {52'd0, o12[11:0]}, 64'h5A5);
      check("crc_en_during_scan", {63'd0, crc_ok}, 64'd1);

      // slot 2 mismatch
      compare(16'h1111, 16'h1111);
      pulse_uir(IR_INC_COUNTER);
      compare(16'hABCD, 16'hABCD);
      pulse_uir(IR_INC_COUNTER);
      compare(16'h1234, 16'h1235);
      @(negedge tck);
      check("verify_fail_set", {63'd0, vf16}, 64'd1);
      pulse_uir(IR_READ_ERRLOG);
      scan(13, 64'd0, o16, o12);
      check("errlog_slot2_16", o16, 64'h1201);
      check("errlog_slot2_12", o12, 64'h1201);
      pulse_uir(IR_LOAD_RESET_SHIFT);
      scan(16, 64'd0, o16, o12);
      check("status_slot2_16", o16, 64'hFFFB);
      check("status_slot2_12", {52'd0, o12[11:0]}, 64'hFFB);

      // mask out bit 0, same data now matches
      set_ir(IR_LOAD_MASK);
      scan(16, 64'hFFFE, o16, o12);
      check("mask_shift_reset_out", o16, 64'hFFFF);
      pulse_udr();
      pulse_uir(IR_INC_COUNTER);
      pulse_uir(IR_INC_COUNTER);
      compare(16'h1234, 16'h1235);
      @(negedge tck);
      check("masked_verify_fail", {63'd0, vf16}, 64'd0);
      pulse_uir(IR_READ_ERRLOG);
      scan(13, 64'd0, o16, o12);
      check("masked_errlog", o16, 64'd0);
      pulse_uir(IR_LOAD_RESET_SHIFT);
      scan(16, 64'd0, o16, o12);
      check("masked_status", o16, 64'hFFFF);

      // 13 increments: wraps to 1 at 12 slots
      repeat (13) pulse_uir(IR_INC_COUNTER);
      compare(16'h0002, 16'h0000);
      pulse_uir(IR_READ_ERRLOG);
      scan(13, 64'd0, o16, o12);
      check("wrap_errlog16", o16, 64'h1D01);
      check("wrap_errlog12", o12, 64'h1101);
      pulse_uir(IR_LOAD_RESET_SHIFT);
      scan(16, 64'd0, o16, o12);
      check("wrap_status16", o16, 64'hDFFF);
      check("wrap_status12", {52'd0, o12[11:0]}, 64'hFFD);

      // saturating error counter, first slot kept
      repeat (3) pulse_uir(IR_INC_COUNTER);
      repeat (300) compare(16'h0002, 16'h0000);
      pulse_uir(IR_INC_COUNTER);
      compare(16'h0002, 16'h0000);
      pulse_uir(IR_READ_ERRLOG);
      scan(13, 64'd0, o16, o12);
      check("sat_errlog16", o16, 64'h13FF);
      check("sat_errlog12", o12, 64'h13FF);

      // reset in the middle of a status scan
      pulse_uir(IR_INFO);
      pulse_uir(IR_LOAD_RESET_SHIFT);
      scan(5, 64'd0, o16, o12);
      check("midscan_bits16", o16, 64'h05);
      check("midscan_bits12", o12, 64'h05);
      pulse_uir(IR_INFO);
      set_ir(IR_LOAD_RESET_SHIFT);
      @(negedge tck);
      rst = 1'b1;
      @(negedge tck);
      rst = 1'b0;
      scan(16, 64'hFFFF, o16, o12);
      check("postreset_status_chain16", o16, 64'd0);
      check("postreset_status_chain12", {52'd0, o12[11:0]}, 64'd0);
      check("postreset_verify_fail", {63'd0, vf16}, 64'd0);
      set_ir(IR_READ_ERRLOG);
      scan(13, 64'd0, o16, o12);
      check("postreset_errlog_chain", o16, 64'd0);
      set_ir(IR_LOAD_MASK);
      scan(16, 64'd0, o16, o12);
      check("postreset_mask_shift", o16, 64'hFFFF);
      pulse_uir(IR_LOAD_RESET_SHIFT);
      scan(16, 64'd0, o16, o12);
      check("postreset_status16", o16, 64'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alt_pfl_pgm_verify_multi.md
# alt_pfl_pgm_verify_multi

Parametrised on-chip verify engine for the PFL programming path, driven over virtual JTAG. It compares flash read-back data against IP-side reference data into NUM_SLOTS sticky status bits, under a JTAG-loadable compare mask. It also keeps a saturating mismatch counter and a first-failing-slot log, both readable through a second scan chain. It sits between the vJTAG hub decode and the flash read datapath, and drives the CRC-verify enable.

## Interface
- DATA_WIDTH, 16, flash/reference data width
- PFL_IR_BITS, 5, virtual IR width
- NUM_SLOTS, 16, status slots (2..64); SLOT_BITS = max(1, clog2(NUM_SLOTS))
- ERR_CNT_WIDTH, 8, mismatch counter width
- IR_INFO 'h11, IR_READ_DATA 'h12, IR_FIFOSM_EXIT 'h0F, IR_LOAD_RESET_SHIFT 'h1C, IR_INC_COUNTER 'h1D, IR_LOAD_MASK 'h1E, IR_READ_ERRLOG 'h1B: IR codes
- vjtag_tck  in  1  sole clock
- vjtag_reset  in  1  synchronous, active-high reset
- vjtag_tdi  in  1  scan data in
- vjtag_virtual_state_sdr / _uir / _udr / _cdr  in  1 each  vJTAG state strobes
- vjtag_ir_in  in  PFL_IR_BITS  current virtual IR
- flash_data_in  in  DATA_WIDTH  flash read-back data
- ip_flash_data_in  in  DATA_WIDTH  reference data
- vjtag_tdo  out  1  scan data out
- crc_verify_enable  out  1  combinational: vjtag_ir_in == IR_LOAD_RESET_SHIFT
- verify_fail  out  1  registered: any verify_status bit is 0

## Operation
- Capture: on CDR with IR_READ_DATA, flash_reg <= flash_data_in.
- Compare (combinational): match = ((flash_reg ^ ip_flash_data_in) & mask) == 0.
- Slot counter (SLOT_BITS):
  - cleared on UIR with IR_LOAD_RESET_SHIFT.
  - incremented on UIR with IR_INC_COUNTER; wraps NUM_SLOTS-1 -> 0, including for non-power-of-2 NUM_SLOTS.
- verify_status[NUM_SLOTS-1:0], priority order:
  - reset -> all ones.
  - UIR + LOAD_RESET_SHIFT -> all ones.
  - UIR + INFO -> 'hA5 repeated, truncated to NUM_SLOTS.
  - UIR + FIFOSM_EXIT -> 'hC3 repeated, truncated.
  - UDR + READ_DATA -> status[slot] &= match.
- err_count: cleared by reset or UIR + LOAD_RESET_SHIFT; on UDR + READ_DATA with !match, increments, saturating at all ones.
- first_fail_valid/first_fail_slot: same clear events. On the first mismatch after a clear, latch slot and set valid; later mismatches are ignored.
- Status chain (NUM_SLOTS bits, shift right, LSB = tdo):
  - parallel-loads verify_status on UIR + LOAD_RESET_SHIFT. It captures the pre-clear value, because load and clear share that edge.
  - shifts vjtag_tdi in on SDR + LOAD_RESET_SHIFT.
- Errlog chain ({first_fail_valid, first_fail_slot, err_count}, err_count at LSB):
  - loads on UIR + READ_ERRLOG.
  - shifts on SDR + READ_ERRLOG; vjtag_tdi enters at the MSB.
- Mask:
  - shift stage shifts on SDR + LOAD_MASK.
  - mask register <= shift stage on UDR + LOAD_MASK.
  - reset value of both is all ones (full compare).
- vjtag_tdo mux on IR:
  - LOAD_RESET_SHIFT -> status chain LSB.
  - READ_ERRLOG -> errlog chain LSB.
  - LOAD_MASK -> mask shift LSB.
  - otherwise 0.

## Timing
- All state updates on posedge vjtag_tck; strobes sampled at that edge.
- Reset values: verify_status all ones; verify_fail 0; counters, first-fail log, flash_reg and the status/errlog chains 0; mask and mask shift all ones; vjtag_tdo 0 (given those reset values).
- Compare result is visible at the UDR edge following CDR capture; there is no pipeline in the compare.
- verify_fail updates one cycle after verify_status changes.
- UIR + INC_COUNTER and UDR + READ_DATA never coincide (different IR values). Status-clear priority wins over the capture-based updates.
- Reset asserted mid-scan aborts the scan: chains clear and the next SDR shifts from the reset value.
- A mask update takes effect on the first compare after the UDR edge.

## Structure
- Package alt_pfl_verify_pkg holds:
  - IR code localparams.
  - the 'hA5/'hC3 pattern bytes.
  - a pattern-replication function (byte -> NUM_SLOTS bits).
- Sub-module alt_pfl_jtag_shifter:
  - parameter WIDTH; ports clk, reset, enable, load, data, shiftin, shiftout.
  - instantiated three times: status, errlog and mask shift stage.

## Test plan
- Reset, then UIR INFO, then LOAD_RESET_SHIFT UIR + 16 SDR (NUM_SLOTS=16) -> tdo serial 'hA5A5 LSB first; crc_verify_enable high throughout.
- Reset status; slot 0 and slot 1 READ_DATA with matching data; slot 2 flash='h1234, ref='h1235 -> status 'hFFFB, err_count 1, first_fail_slot 2, verify_fail 1.
- Load mask 'hFFFE, repeat the slot-2 compare -> match; status bit 2 remains 1 after a fresh clear.
- NUM_SLOTS=12: 13 INC_COUNTER pulses -> slot 1; mismatch clears status bit 1 only.
- 300 mismatches with ERR_CNT_WIDTH=8 -> READ_ERRLOG scan shows err_count 'hFF, first_fail_slot is the first failing slot.
- Reset asserted mid-SDR of the status chain -> all chains return to reset values; the next shift starts cleanly.
